axi_wr_arbiter: RTL

- Round-robin arbiter that shares one downstream AXI write port (AW/W/B) among NREQ upstream requesters.
- Grants one requester at a time and holds the grant for the full transaction: address handshake, all data beats (burst length from awlen), then the write response.
- Sits between requester-side write FSMs and the AXI protocol write channel; generates WLAST downstream from its own beat counter.

---
 rtl/axi_wr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one downstream AXI write port (AW/W/B) among NREQ requesters.
// The grant is held for a whole transaction; WLAST downstream comes from the local beat counter.
module axi_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 64
) (
  input  logic                   axi_aclk,
  input  logic                   rst,
  input  logic [NREQ*AW-1:0]     req_awaddr,
  input  logic [NREQ*8-1:0]      req_awlen,
  input  logic [NREQ*3-1:0]      req_awsize,
  input  logic [NREQ*2-1:0]      req_awburst,
  input  logic [NREQ-1:0]        req_awvalid,
  output logic [NREQ-1:0]        req_awready,
  input  logic [NREQ*DW-1:0]     req_wdata,
  input  logic [NREQ*DW/8-1:0]   req_wstrb,
  input  logic [NREQ-1:0]        req_wlast,
  input  logic [NREQ-1:0]        req_wvalid,
  output logic [NREQ-1:0]        req_wready,
  output logic [1:0]             req_bresp,
  output logic [NREQ-1:0]        req_bvalid,
  input  logic [NREQ-1:0]        req_bready,
  output logic [AW-1:0]          m_awaddr,
  output logic [7:0]             m_awlen,
  output logic [2:0]             m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [DW-1:0]          m_wdata,
  output logic [DW/8-1:0]        m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   wlast_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_gIdx;
  logic [IW-1:0]   r_lastGrant;
  logic [7:0]      r_beatCnt;
  logic            r_wlastErr;

  logic            w_found;
  logic [IW-1:0]   w_pickIdx;
  logic [IW-1:0]   w_cand;
  logic            w_awHs;
  logic            w_wHs;
  logic            w_bHs;

  // Round-robin search starting just after the previously served requester.
  always_comb begin
    w_found   = 1'b0;
    w_pickIdx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_lastGrant) + k) % NREQ);
      if (!w_found && req_awvalid[w_cand]) begin
        w_found   = 1'b1;
        w_pickIdx = w_cand;
      end
    end
  end

  assign m_awaddr  = req_awaddr[r_gIdx*AW +: AW];
  assign m_awlen   = req_awlen[r_gIdx*8 +: 8];
  assign m_awsize  = req_awsize[r_gIdx*3 +: 3];
  assign m_awburst = req_awburst[r_gIdx*2 +: 2];
  assign m_wdata   = req_wdata[r_gIdx*DW +: DW];
  assign m_wstrb   = req_wstrb[r_gIdx*SW +: SW];
  assign m_wlast   = (r_state == DATA) && (r_beatCnt == 8'd0);
  assign req_bresp = m_bresp;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
  assign wlast_err = r_wlastErr;

  // Handshake signals are routed only through the current phase, so IDLE keeps them all low.
  always_comb begin
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    req_awready = '0;
    req_wready  = '0;
    req_bvalid  = '0;
    case (r_state)
      ADDR: begin
        m_awvalid           = req_awvalid[r_gIdx];
        req_awready[r_gIdx] = m_awready;
      end
      DATA: begin
        m_wvalid           = req_wvalid[r_gIdx];
        req_wready[r_gIdx] = m_wready;
      end
      RESP: begin
        m_bready           = req_bready[r_gIdx];
        req_bvalid[r_gIdx] = m_bvalid;
      end
      default: ;
    endcase
  end

  assign w_awHs = m_awvalid && m_awready;
  assign w_wHs  = m_wvalid && m_wready;
  assign w_bHs  = m_bvalid && m_bready;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_found) w_nextState = ADDR;
      ADDR: if (w_awHs) w_nextState = DATA;
      DATA: if (w_wHs && (r_beatCnt == 8'd0)) w_nextState = RESP;
      RESP: if (w_bHs) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Grant bookkeeping and beat counting; the counter stops at zero instead of wrapping.
  always_ff @(posedge axi_aclk or posedge rst) begin
    if (rst) begin
      r_grant     <= '0;
      r_gIdx      <= '0;
      r_lastGrant <= IW'(NREQ - 1);
      r_beatCnt   <= 8'd0;
      r_wlastErr  <= 1'b0;
    end else begin
      r_wlastErr <= w_wHs && (req_wlast[r_gIdx] != m_wlast);
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= NREQ'(1) << w_pickIdx;
          r_gIdx  <= w_pickIdx;
        end
        ADDR: if (w_awHs) r_beatCnt <= m_awlen;
        DATA: if (w_wHs && (r_beatCnt != 8'd0)) r_beatCnt <= r_beatCnt - 8'd1;
        RESP: if (w_bHs) begin
          r_lastGrant <= r_gIdx;
          r_grant     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
